// File: rtl/ec1_pkg.sv
// EC-1 shared definitions: default datapath widths and the opcode encoding
// that the control unit decodes from the IR field of the datapath.
package ec1_pkg;

  localparam int unsigned EC1_DATA_W = 8;
  localparam int unsigned EC1_ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_IN   = 3'b011,
    OP_OUT  = 3'b100,
    OP_DEC  = 3'b101,
    OP_JNZ  = 3'b110,
    OP_HALT = 3'b111
  } ec1_op_e;

endpackage

// File: rtl/ec1_prog_mem.sv
// EC-1 program memory: 2^ADDR_W x DATA_W words, one synchronous write port
// and one combinational read port. Contents are not initialised and are not
// affected by reset.
//   clk      rising-edge write clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational, returns pre-edge contents)
module ec1_prog_mem
  import ec1_pkg::*;
#(
  parameter int unsigned DATA_W = EC1_DATA_W,
  parameter int unsigned ADDR_W = EC1_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ec1_datapath.sv
// EC-1 accumulator machine datapath: PC, IR, accumulator, program memory and
// output register. Executes the load strobes from the control unit and
// returns the opcode and accumulator-nonzero status.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (registers only, not memory)
//   IRload     IR <= mem[PC]
//   PCload     update PC (JNZmux: 1 = IR jump target, 0 = PC+1)
//   INmux      A source (1 = in_data, 0 = A-1)
//   Aload      update accumulator
//   JNZmux     PC source select
//   OutE       latch accumulator into out_data, pulse out_valid
//   Halt1      halt request (sticky until reset)
//   in_data    external operand
//   prog_*     program memory write port
//   IR         opcode field of the IR
//   A          accumulator nonzero
//   out_data   output register
//   out_valid  one-cycle pulse after each accepted OutE
//   halted     sticky halt flag
//   pc         current PC
module ec1_datapath
  import ec1_pkg::*;
#(
  parameter int unsigned DATA_W = EC1_DATA_W,
  parameter int unsigned ADDR_W = EC1_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IRload,
  input  logic              PCload,
  input  logic              INmux,
  input  logic              Aload,
  input  logic              JNZmux,
  input  logic              OutE,
  input  logic              Halt1,
  input  logic [DATA_W-1:0] in_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [2:0]        IR,
  output logic              A,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              run;

  ec1_prog_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  // Halt gates the register strobes from the cycle after Halt1 is sampled.
  assign run = !halted_q;

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q | Halt1;
    if (run) begin
      if (IRload) begin
        ir_d = mem_rdata;
      end
      if (PCload) begin
        pc_d = JNZmux ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
      end
      if (Aload) begin
        acc_d = INmux ? in_data : acc_q - 1'b1;
      end
      if (OutE) begin
        out_d       = acc_q;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign IR        = ir_q[DATA_W-1 -: 3];
  assign A         = |acc_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_ec1_datapath.sv
module tb_ec1_datapath;
  import ec1_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       IRload, PCload, INmux, Aload, JNZmux, OutE, Halt1;
  logic [7:0] in_data;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] IR;
  logic       A;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [4:0] pc;

  ec1_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .IRload(IRload), .PCload(PCload), .INmux(INmux),
    .Aload(Aload), .JNZmux(JNZmux), .OutE(OutE), .Halt1(Halt1), .in_data(in_data),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .IR(IR), .A(A),
    .out_data(out_data), .out_valid(out_valid), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  // Reference machine state, kept as plain integers.
  int m_mem [32];
  int m_pc, m_ir, m_acc, m_out;
  bit m_halt;
  int sb [$];
  int outlog [$];
  bit log_en = 1'b0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Output monitor: every out_valid pulse must match the oldest queued value.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("sb_out_data", int'(out_data), sb.pop_front());
        end
        if (log_en) outlog.push_back(int'(out_data));
      end
    end
  end

  task automatic set_reset(input bit v);
    reset = v;
    if (!v) begin
      m_pc = 0; m_ir = 0; m_acc = 0; m_out = 0; m_halt = 1'b0;
      sb.delete();
    end
  endtask

  // Drive one strobe set, advance the model, clock, then compare everything.
  task automatic step(input bit irl, input bit pcl, input bit inm, input bit al,
                      input bit jm, input bit oe, input bit h1, input int din,
                      input bit we, input int wa, input int wd);
    bit exp_v;
    int npc, nir, nacc, nout;
    IRload = irl; PCload = pcl; INmux = inm; Aload = al; JNZmux = jm;
    OutE = oe; Halt1 = h1; in_data = din[7:0];
    prog_we = we; prog_addr = wa[4:0]; prog_data = wd[7:0];
    exp_v = 1'b0;
    if (reset) begin
      npc = m_pc; nir = m_ir; nacc = m_acc; nout = m_out;
      if (!m_halt) begin
        if (irl) nir = m_mem[m_pc];
        if (pcl) npc = jm ? (m_ir % 32) : (m_pc + 1) % 32;
        if (al)  nacc = inm ? (din % 256) : (m_acc + 255) % 256;
        if (oe) begin
          nout = m_acc;
          exp_v = 1'b1;
          sb.push_back(m_acc);
        end
      end
      if (h1) m_halt = 1'b1;
      m_pc = npc; m_ir = nir; m_acc = nacc; m_out = nout;
    end
    if (we) m_mem[wa % 32] = wd % 256;
    @(posedge clk);
    #1;
    chk("pc", int'(pc), m_pc);
    chk("ir_op", int'(IR), m_ir / 32);
    chk("a_nz", int'(A), (m_acc != 0) ? 1 : 0);
    chk("halted", int'(halted), int'(m_halt));
    chk("out_data", int'(out_data), m_out);
    chk("out_valid", int'(out_valid), int'(exp_v));
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int save_pc, save_out;
  int op;

  initial begin
    reset = 1'b0;
    IRload = 0; PCload = 0; INmux = 0; Aload = 0; JNZmux = 0; OutE = 0; Halt1 = 0;
    in_data = '0; prog_we = 0; prog_addr = '0; prog_data = '0;
    set_reset(1'b0);
    @(posedge clk);
    #2;

    // Reset held: every strobe pulsed while memory is filled.
    for (int i = 0; i < 32; i++) begin
      step(1, 1, i[0], 1, i[1], 1, 1, $urandom_range(0, 255), 1, i, $urandom_range(0, 255));
    end
    chk("rst_pc", int'(pc), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_halted", int'(halted), 0);

    // Fetch and wrap
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 8'hA0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h60);
    set_reset(1'b1);
    for (int i = 0; i < 31; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc31", int'(pc), 31);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_ir", int'(IR), int'(OP_DEC));
    chk("wrap_pc0", int'(pc), 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch0_ir", int'(IR), int'(OP_IN));
    chk("fetch0_pc", int'(pc), 1);

    // Accumulator
    step(0, 0, 1, 1, 0, 0, 0, 8'h01, 0, 0, 0);
    chk("acc_load1", int'(A), 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("acc_dec0", int'(A), 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("acc_decff", int'(A), 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("out_ff", int'(out_data), 8'hFF);
    chk("out_pulse_hi", int'(out_valid), 1);
    idle();
    chk("out_pulse_lo", int'(out_valid), 0);

    // Jump; memory write and IRload to the same address in one cycle
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, m_pc, 8'hC7);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("jnz_pc", int'(pc), 7);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("jnz_hold", int'(pc), 7);

    // Halt
    step(0, 0, 1, 1, 0, 0, 1, 8'h5A, 0, 0, 0);
    save_pc = m_pc; save_out = m_out;
    step(1, 1, 1, 1, 0, 1, 0, 8'h33, 0, 0, 0);
    step(1, 1, 0, 1, 1, 1, 0, 8'h33, 0, 0, 0);
    chk("halt_flag", int'(halted), 1);
    chk("halt_pc", int'(pc), save_pc);
    chk("halt_out", int'(out_data), save_out);
    set_reset(1'b0);
    idle();
    set_reset(1'b1);
    idle();
    chk("halt_cleared", int'(halted), 0);

    // Integrated program run, bench acting as the control unit
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h60);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h80);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 8'hA0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 8'hC1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 8'hE0);
    set_reset(1'b0);
    idle();
    set_reset(1'b1);
    outlog.delete();
    log_en = 1'b1;
    for (int n = 0; n < 40 && !m_halt; n++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      op = m_ir / 32;
      case (op)
        3: step(0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0);
        4: step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        5: step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        6: if (m_acc != 0) step(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
           else idle();
        7: step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        default: idle();
      endcase
    end
    idle();
    log_en = 1'b0;
    chk("prog_halted", int'(halted), 1);
    chk("prog_pc", int'(pc), 5);
    chk("prog_nout", outlog.size(), 3);
    for (int i = 0; i < outlog.size() && i < 3; i++) chk("prog_out", outlog[i], 3 - i);

    // Randomized strobes with occasional writes, halts and resets
    for (int i = 0; i < 600; i++) begin
      if (!reset) set_reset(1'b1);
      else if ($urandom_range(0, 59) == 0) set_reset(1'b0);
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 49) == 0), $urandom_range(0, 255),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0) ? m_pc : $urandom_range(0, 31),
           $urandom_range(0, 255));
    end
    idle();
    idle();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
